// File: rtl/hps_loan_io_pkg.sv
// hps_loan_io_pkg
// Shared definitions for the HPS loan-IO controller: channel mode encoding,
// Avalon-MM register word addresses and the bus data width.
package hps_loan_io_pkg;

   localparam int DATA_W = 32;

   // Per-channel pin mode, as written into the MODE register (2 bits/channel)
   typedef enum logic [1:0] {
      MODE_IN    = 2'b00,
      MODE_PP    = 2'b01,
      MODE_OD    = 2'b10,
      MODE_PULSE = 2'b11
   } io_mode_t;

   // Register word addresses; 6 and 7 are unused and read as zero
   localparam logic [2:0] ADDR_MODE  = 3'd0;
   localparam logic [2:0] ADDR_DOUT  = 3'd1;
   localparam logic [2:0] ADDR_DIN   = 3'd2;
   localparam logic [2:0] ADDR_EDGE  = 3'd3;
   localparam logic [2:0] ADDR_IMASK = 3'd4;
   localparam logic [2:0] ADDR_ESEL  = 3'd5;

endpackage

// File: rtl/hps_loan_io_debounce.sv
// hps_loan_io_debounce
// One input channel: 2-FF synchroniser, stability counter and edge strobes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pin_async       raw pin level (asynchronous to clk)
//   din             debounced, registered level
//   rise, fall      one-cycle strobes, high in the cycle before din changes,
//                   so a register sampling them updates together with din
module hps_loan_io_debounce #(
   parameter int DEB_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_async,
   output logic din,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_reg;
   logic          deb_reg;
   logic          din_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
         deb_reg  <= 1'b0;
         din_reg  <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[0], pin_async};
         din_reg  <= deb_reg;
         // Count consecutive cycles of disagreement; any agreement restarts it
         if (sync_reg[1] == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            deb_reg <= sync_reg[1];
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign din  = din_reg;
   assign rise = deb_reg & ~din_reg;
   assign fall = ~deb_reg & din_reg;

endmodule

// File: rtl/hps_loan_io_ctrl.sv
// hps_loan_io_ctrl
// Avalon-MM controlled driver for NUM_CH HPS loan-IO pins. Each channel can be
// an input, push-pull, open-drain or one-shot pulse output; every channel's pin
// is also synchronised, debounced and edge-captured with a maskable interrupt.
// Ports:
//   clk_clk, reset_reset_n       clock, asynchronous active-low reset
//   avs_address/read/write/...   lightweight H2F bridge slave, 1-cycle read
//   irq                          level interrupt, |(EDGE & IMASK), registered
//   loan_in/loan_out/loan_oe     h2f_loan_io conduit
module hps_loan_io_ctrl
   import hps_loan_io_pkg::*;
#(
   parameter int                LOAN_WIDTH = 67,
   parameter int                NUM_CH     = 4,
   parameter logic [7*NUM_CH-1:0] CH_IDX   = {7'd54, 7'd53, 7'd50, 7'd49},
   parameter int                DEB_CYCLES = 1000,
   parameter int                PULSE_LEN  = 50000
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [2:0]            avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [DATA_W-1:0]     avs_writedata,
   output logic [DATA_W-1:0]     avs_readdata,
   output logic                  irq,
   input  logic [LOAN_WIDTH-1:0] loan_in,
   output logic [LOAN_WIDTH-1:0] loan_out,
   output logic [LOAN_WIDTH-1:0] loan_oe
);

   localparam int PW = $clog2(PULSE_LEN + 1);

   logic [2*NUM_CH-1:0]   mode_reg;
   logic [NUM_CH-1:0]     dout_reg, dout_next;
   logic [NUM_CH-1:0]     edge_reg, edge_set, edge_clr;
   logic [NUM_CH-1:0]     imask_reg;
   logic [2*NUM_CH-1:0]   esel_reg;
   logic                  irq_reg;
   logic [DATA_W-1:0]     rdata_reg, rdata_next;
   logic [LOAN_WIDTH-1:0] out_reg, out_next, oe_reg, oe_next;

   logic [NUM_CH-1:0]     ch_out, ch_oe, ch_din, ch_rise, ch_fall, pulse_done;

   logic wr_mode, wr_dout, wr_edge, wr_imask, wr_esel;
   logic unused_bits;

   assign wr_mode  = avs_write && (avs_address == ADDR_MODE);
   assign wr_dout  = avs_write && (avs_address == ADDR_DOUT);
   assign wr_edge  = avs_write && (avs_address == ADDR_EDGE);
   assign wr_imask = avs_write && (avs_address == ADDR_IMASK);
   assign wr_esel  = avs_write && (avs_address == ADDR_ESEL);

   // Unmapped loan inputs and unused write-data bits are intentionally ignored
   assign unused_bits = ^{loan_in, avs_writedata};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         io_mode_t      mode_cur, mode_new;
         logic [PW-1:0] pcnt_reg;
         logic          pulse_hi;

         assign mode_cur = io_mode_t'(mode_reg[2*gi +: 2]);
         assign mode_new = io_mode_t'(avs_writedata[2*gi +: 2]);

         // Pulse timer: loaded by DOUT=1 in pulse mode, cleared by DOUT=0 or
         // by any change of this channel's mode
         always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
               pcnt_reg <= '0;
            end else if (wr_mode && (mode_new != mode_cur)) begin
               pcnt_reg <= '0;
            end else if (wr_dout && (mode_cur == MODE_PULSE)) begin
               pcnt_reg <= avs_writedata[gi] ? PW'(PULSE_LEN) : '0;
            end else if (pcnt_reg != '0) begin
               pcnt_reg <= pcnt_reg - PW'(1);
            end
         end

         assign pulse_hi       = (pcnt_reg != '0);
         assign pulse_done[gi] = (pcnt_reg == PW'(1));

         assign ch_out[gi] = ((mode_cur == MODE_PP) && dout_reg[gi]) ||
                             ((mode_cur == MODE_PULSE) && pulse_hi);
         assign ch_oe[gi]  = (mode_cur == MODE_PP) || (mode_cur == MODE_PULSE) ||
                             ((mode_cur == MODE_OD) && !dout_reg[gi]);

         hps_loan_io_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_deb (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .pin_async (loan_in[CH_IDX[7*gi +: 7]]),
            .din       (ch_din[gi]),
            .rise      (ch_rise[gi]),
            .fall      (ch_fall[gi])
         );
      end
   endgenerate

   // DOUT bits in pulse mode self-clear as their timer runs out; a
   // simultaneous bus write takes priority
   assign dout_next = wr_dout ? avs_writedata[NUM_CH-1:0] : (dout_reg & ~pulse_done);

   assign edge_set = (ch_rise & esel_reg[NUM_CH-1:0]) |
                     (ch_fall & esel_reg[2*NUM_CH-1:NUM_CH]);
   assign edge_clr = wr_edge ? avs_writedata[NUM_CH-1:0] : '0;

   always_comb begin
      out_next = '0;
      oe_next  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         out_next[CH_IDX[7*i +: 7]] = ch_out[i];
         oe_next[CH_IDX[7*i +: 7]]  = ch_oe[i];
      end
   end

   always_comb begin
      rdata_next = '0;
      case (avs_address)
         ADDR_MODE:  rdata_next[2*NUM_CH-1:0] = mode_reg;
         ADDR_DOUT:  rdata_next[NUM_CH-1:0]   = dout_reg;
         ADDR_DIN:   rdata_next[NUM_CH-1:0]   = ch_din;
         ADDR_EDGE:  rdata_next[NUM_CH-1:0]   = edge_reg;
         ADDR_IMASK: rdata_next[NUM_CH-1:0]   = imask_reg;
         ADDR_ESEL:  rdata_next[2*NUM_CH-1:0] = esel_reg;
         default:    ;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         mode_reg  <= '0;
         dout_reg  <= '0;
         edge_reg  <= '0;
         imask_reg <= '0;
         esel_reg  <= '0;
         irq_reg   <= 1'b0;
         rdata_reg <= '0;
         out_reg   <= '0;
         oe_reg    <= '0;
      end else begin
         if (wr_mode)  mode_reg  <= avs_writedata[2*NUM_CH-1:0];
         if (wr_imask) imask_reg <= avs_writedata[NUM_CH-1:0];
         if (wr_esel)  esel_reg  <= avs_writedata[2*NUM_CH-1:0];
         dout_reg <= dout_next;
         // A new edge wins over a W1C of the same bit
         edge_reg <= (edge_reg & ~edge_clr) | edge_set;
         irq_reg  <= |(edge_reg & imask_reg);
         if (avs_read) rdata_reg <= rdata_next;
         out_reg  <= out_next;
         oe_reg   <= oe_next;
      end
   end

   assign avs_readdata = rdata_reg;
   assign irq          = irq_reg;
   assign loan_out     = out_reg;
   assign loan_oe      = oe_reg;

endmodule

// File: tb/tb_hps_loan_io_ctrl.sv
// tb_hps_loan_io_ctrl
// Directed bench for hps_loan_io_ctrl with DEB_CYCLES=4 and PULSE_LEN=8.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Default CH_IDX maps channel 0..3 to loan bits 49, 50, 53, 54.
module tb_hps_loan_io_ctrl;
   import hps_loan_io_pkg::*;

   localparam int LW   = 67;
   localparam int NCH  = 4;
   localparam int DEB  = 4;
   localparam int PLEN = 8;
   localparam int PIN0 = 49;
   localparam int PIN1 = 50;
   localparam int PIN3 = 54;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic [2:0]        avs_address = '0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic [31:0]       avs_readdata;
   logic              irq;
   logic [LW-1:0]     loan_in = '0;
   logic [LW-1:0]     loan_out;
   logic [LW-1:0]     loan_oe;

   int n_checks = 0;
   int n_errors = 0;

   hps_loan_io_ctrl #(
      .LOAN_WIDTH (LW),
      .NUM_CH     (NCH),
      .CH_IDX     ({7'd54, 7'd53, 7'd50, 7'd49}),
      .DEB_CYCLES (DEB),
      .PULSE_LEN  (PLEN)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .loan_in       (loan_in),
      .loan_out      (loan_out),
      .loan_oe       (loan_oe)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("check %s: 0x%0h ok", tag, got);
      end
   endtask

   function automatic logic [LW-1:0] bit_at(input int b);
      logic [LW-1:0] v;
      v    = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // Write is sampled by the next rising edge; returns on the following falling edge
   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk_clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
      avs_address = addr;
      avs_read    = 1'b1;
      @(negedge clk_clk);
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   // Samples loan_out[PIN3] once per cycle for cyc cycles; optionally issues a
   // DOUT write that is sampled by rising edge number rewrite_at
   task automatic run_pulse(input int cyc, input int rewrite_at, input logic [31:0] rewrite_val,
                            output int highs, output int first);
      highs = 0;
      first = 0;
      for (int k = 1; k <= cyc; k++) begin
         if (k == rewrite_at) begin
            avs_address   = ADDR_DOUT;
            avs_writedata = rewrite_val;
            avs_write     = 1'b1;
         end
         @(negedge clk_clk);
         avs_write = 1'b0;
         if (loan_out[PIN3]) begin
            highs++;
            if (first == 0) first = k;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      int highs, first;

      // ---------------- reset state ----------------
      tick(3);
      check_value("reset_oe", loan_oe, '0);
      check_value("reset_out", loan_out, '0);
      check_value("reset_irq", irq, 1'b0);
      check_value("reset_rdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;
      tick(2);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check_value($sformatf("reset_reg%0d", a), rd, 32'h0);
      end
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_read(3'd6, rd);
      check_value("unused_addr6", rd, 32'h0);

      // ---------------- push-pull / open-drain on channel 0 ----------------
      bus_write(ADDR_MODE, 32'h1);
      check_value("pp_oe_not_yet", loan_oe, '0);
      tick(1);
      check_value("pp_oe", loan_oe, bit_at(PIN0));
      check_value("pp_out_low", loan_out, '0);
      bus_write(ADDR_DOUT, 32'h1);
      tick(1);
      check_value("pp_out_high", loan_out, bit_at(PIN0));
      bus_write(ADDR_MODE, 32'h2);
      tick(1);
      check_value("od_released_oe", loan_oe, '0);
      check_value("od_released_out", loan_out, '0);
      bus_write(ADDR_DOUT, 32'h0);
      tick(1);
      check_value("od_drive_oe", loan_oe, bit_at(PIN0));
      check_value("od_drive_out", loan_out, '0);
      bus_read(ADDR_MODE, rd);
      check_value("mode_readback", rd, 32'h2);
      bus_write(ADDR_MODE, 32'h0);
      tick(1);
      check_value("input_oe", loan_oe, '0);

      // ---------------- debounce on channel 1 (loan bit 50) ----------------
      loan_in[PIN1] = 1'b1;        // 3-cycle glitch, shorter than DEB
      tick(3);
      loan_in[PIN1] = 1'b0;
      tick(10);
      bus_read(ADDR_DIN, rd);
      check_value("glitch_din", rd, 32'h0);

      // Continuous read of DIN: readdata after edge k shows DIN as of edge k-1.
      // DIN rises at edge 2+4+1 = 7 after the first high, so readdata at edge 8.
      avs_address = ADDR_DIN;
      avs_read    = 1'b1;
      tick(2);
      loan_in[PIN1] = 1'b1;
      tick(7);
      check_value("din_edge7", avs_readdata, 32'h0);
      tick(1);
      check_value("din_edge8", avs_readdata, 32'h2);
      avs_read = 1'b0;
      tick(4);
      loan_in[PIN1] = 1'b0;
      tick(12);
      bus_read(ADDR_DIN, rd);
      check_value("din_low_again", rd, 32'h0);

      // ---------------- edge capture and irq ----------------
      bus_write(ADDR_ESEL, 32'h2);
      bus_write(ADDR_IMASK, 32'h2);
      loan_in[PIN1] = 1'b1;        // EDGE sets at edge 7, irq at edge 8
      tick(7);
      check_value("irq_edge7", irq, 1'b0);
      tick(1);
      check_value("irq_edge8", irq, 1'b1);
      bus_read(ADDR_EDGE, rd);
      check_value("edge_rise", rd, 32'h2);
      bus_write(ADDR_EDGE, 32'h2);
      check_value("irq_still_set", irq, 1'b1);
      tick(1);
      check_value("irq_cleared", irq, 1'b0);
      bus_read(ADDR_EDGE, rd);
      check_value("edge_cleared", rd, 32'h0);

      loan_in[PIN1] = 1'b0;        // falling edge not enabled yet
      tick(12);
      bus_read(ADDR_EDGE, rd);
      check_value("no_fall_capture", rd, 32'h0);
      loan_in[PIN1] = 1'b1;
      tick(6);
      bus_write(ADDR_EDGE, 32'h2); // W1C sampled at edge 7, same as the new edge
      bus_read(ADDR_EDGE, rd);
      check_value("w1c_vs_edge", rd, 32'h2);
      check_value("w1c_vs_edge_irq", irq, 1'b1);

      bus_write(ADDR_EDGE, 32'h2);
      bus_write(ADDR_ESEL, 32'h20); // fall enable for channel 1
      loan_in[PIN1] = 1'b0;
      tick(12);
      bus_read(ADDR_EDGE, rd);
      check_value("edge_fall", rd, 32'h2);

      // ---------------- pulse mode on channel 3 (loan bit 54) ----------------
      bus_write(ADDR_MODE, 32'hC0);
      tick(1);
      check_value("pulse_idle_oe", loan_oe, bit_at(PIN3));
      check_value("pulse_idle_out", loan_out, '0);
      bus_write(ADDR_DOUT, 32'h8);
      check_value("pulse_not_yet", loan_out[PIN3], 1'b0);
      run_pulse(20, 0, 32'h0, highs, first);
      check_value("pulse_len", highs, 8);
      check_value("pulse_start", first, 1);
      check_value("pulse_oe_after", loan_oe, bit_at(PIN3));
      bus_read(ADDR_DOUT, rd);
      check_value("pulse_dout_clr", rd, 32'h0);

      bus_write(ADDR_DOUT, 32'h8);
      run_pulse(25, 5, 32'h8, highs, first);
      check_value("pulse_restart_len", highs, 13);

      bus_write(ADDR_DOUT, 32'h8);
      run_pulse(12, 3, 32'h0, highs, first);
      check_value("pulse_abort_len", highs, 3);
      bus_read(ADDR_DOUT, rd);
      check_value("pulse_abort_dout", rd, 32'h0);

      // ---------------- reset during an active pulse ----------------
      bus_write(ADDR_DOUT, 32'h8);
      tick(3);
      check_value("pulse_active", loan_out[PIN3], 1'b1);
      check_value("irq_before_rst", irq, 1'b1);
      #2;
      reset_reset_n = 1'b0;
      #1;
      check_value("rst_async_out", loan_out, '0);
      check_value("rst_async_oe", loan_oe, '0);
      check_value("rst_async_irq", irq, 1'b0);
      tick(2);
      reset_reset_n = 1'b1;
      tick(1);
      bus_read(ADDR_MODE, rd);
      check_value("rst_mode", rd, 32'h0);
      bus_read(ADDR_DOUT, rd);
      check_value("rst_dout", rd, 32'h0);
      bus_read(ADDR_EDGE, rd);
      check_value("rst_edge", rd, 32'h0);
      bus_read(ADDR_IMASK, rd);
      check_value("rst_imask", rd, 32'h0);
      bus_read(ADDR_ESEL, rd);
      check_value("rst_esel", rd, 32'h0);
      tick(1);
      check_value("rst_out_stays", loan_out, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
